interp_phase_scheduler: RTL and testbench
=========================================

Name: interp_phase_scheduler

Overview:
Single-clock sequencer for the 8-phase polyphase CIC interpolator. It runs on the fast (RATE x) clock and generates the low-rate clock-enable, the polyphase index and the accumulator-chain clear, so the branch filters and summing chain can share one clock. It also owns the upstream valid/ready handshake, zero-stuffing on underrun, and the prime/drain sequencing of the comb pipeline.

Parameters:
RATE, 8, interpolation factor; power of 2, >= 2
PHW, 3, phase index width; log2(RATE)
FILL_DEPTH, 8, fast cycles in FILL before out_valid asserts; >= 1
DRAIN_DEPTH, 8, fast cycles of zero-stuffed flush after stop; >= 1
CNT_W, 16, underrun counter width (optional feature only)

Ports:
clk  in  1  fast clock; the codebase's clk_8 rate, named clk here
rst_n  in  1  asynchronous active-low reset
en  in  1  run request, level-sensitive
in_valid  in  1  upstream sample available
in_ready  out  1  sample accepted this cycle when in_valid=1
slow_ce  out  1  low-rate enable for the branch filters
zero_in  out  1  branch input forced to zero this slow_ce
phase  out  PHW  current polyphase index, 0..RATE-1
acc_clr  out  1  synchronous clear for the comb/summing registers
out_valid  out  1  out_comb is meaningful this cycle
busy  out  1  state != IDLE
underrun  out  1  sticky underrun flag

Behaviour:
- Reset is asynchronous and active-low: state=IDLE, phase=0, fill/drain counters=0, underrun=0. All outputs are 0 during reset.
- States:
  - IDLE: phase held at 0. en=1 -> CLR.
  - CLR: one cycle, acc_clr=1 -> FILL. phase is 0 on FILL entry.
  - FILL: counts FILL_DEPTH cycles -> RUN.
  - RUN: steady state.
  - DRAIN: DRAIN_DEPTH cycles -> IDLE if en=0, otherwise -> CLR.
- phase increments every cycle in FILL, RUN and DRAIN, wrapping RATE-1 -> 0. A frame boundary is phase==RATE-1.
- slow_ce=1 exactly when phase==0 in FILL, RUN or DRAIN.
- in_ready=1 exactly when phase==0 in FILL or RUN. A transfer occurs when in_valid & in_ready. There is no backpressure otherwise; a sample not taken at phase 0 waits for the next frame.
- zero_in = slow_ce & (~in_valid | state==DRAIN). This is a combinational path from in_valid. All other outputs decode from registered state only.
- Underrun: phase==0 in RUN with in_valid=0 sets underrun on the next edge. It is sticky and cleared only by reset or on entry to CLR. No underrun is flagged in FILL, though zero-stuffing still applies there.
- out_valid=1 in RUN and DRAIN, 0 elsewhere.
- Stop: en is sampled each cycle. en=0 in FILL or RUN with phase==RATE-1 -> DRAIN on the next edge. Frames therefore always complete. en toggling within a frame has no effect.
- en=0 while in CLR: FILL is still entered, and the stop rule applies from there.
- Latency: en rises, sampled at edge t -> CLR in cycle t+1 -> first in_ready/slow_ce at t+2 -> out_valid first at t+2+FILL_DEPTH.
- Reset mid-operation: immediate return to IDLE. Restarting always passes through CLR.

Optional Feature:
INTERP_UNDERRUN_CNT_EN
- Defined: adds output underrun_cnt [CNT_W-1:0]. It increments on each underrun event, saturates at all-ones, and is cleared by reset and on CLR entry.
- Undefined: the port and counter are absent; only the sticky underrun flag exists.

Test Plan:
1. rst_n=0 with en=1 and in_valid=1 -> all outputs 0, phase=0; no activity until rst_n=1.
2. RATE=8, FILL_DEPTH=8. en=1 from cycle 0, in_valid=1 constantly -> acc_clr in cycle 1; slow_ce/in_ready in cycles 2,10,18,...; phase=0 at those cycles; out_valid from cycle 10; zero_in never 1; underrun=0.
3. As 2, with in_valid=0 only in cycle 18 -> slow_ce=1, zero_in=1, in_ready=1 in cycle 18; underrun=1 from cycle 19 onward; underrun_cnt=1 when macro defined.
4. As 2, en=0 from cycle 20, DRAIN_DEPTH=8:
   - DRAIN entered in cycle 26, after phase 7 in cycle 25; in_ready=0; zero_in=1 in cycle 26.
   - out_valid=1 through cycle 33.
   - IDLE in cycle 34, with busy=0 and out_valid=0.
5. rst_n pulsed low in cycle 13 of RUN -> outputs 0 immediately; after release with en=1 -> acc_clr one cycle later, FILL restarts with phase 0.
6. en re-raised in cycle 28 during DRAIN (after underrun set) -> DRAIN completes; CLR in cycle 34 with acc_clr=1; underrun cleared; first in_ready in cycle 35.

Source files
------------

// File: rtl/interp_phase_scheduler.sv
//------------------------------------------------------------------------------
// interp_phase_scheduler
//
// Fast-clock sequencer for the 8-phase polyphase CIC interpolator. Produces the
// low-rate clock enable, the polyphase index and the comb/summing-chain clear,
// owns the upstream valid/ready handshake, zero-stuffs on underrun and runs the
// prime (FILL) / flush (DRAIN) sequence of the comb pipeline.
//
// Optional feature macro: INTERP_UNDERRUN_CNT_EN
//   defined   -> adds output underrun_cnt, a saturating underrun event counter
//   undefined -> only the sticky underrun flag exists
//
// Ports:
//   clk          fast (RATE x) clock
//   rst_n        asynchronous active-low reset
//   en           run request, level-sensitive
//   in_valid     upstream sample available
//   in_ready     sample accepted this cycle when in_valid=1 (phase 0, FILL/RUN)
//   slow_ce      low-rate enable for the branch filters (phase 0, FILL/RUN/DRAIN)
//   zero_in      branch input forced to zero on this slow_ce
//   phase        current polyphase index, 0..RATE-1
//   acc_clr      synchronous clear for the comb/summing registers (CLR state)
//   out_valid    output of the comb chain is meaningful (RUN/DRAIN)
//   busy         sequencer not idle
//   underrun     sticky underrun flag, cleared by reset or entry to CLR
//   underrun_cnt saturating underrun event count (macro build only)
//------------------------------------------------------------------------------
module interp_phase_scheduler #(
   parameter int RATE        = 8,
   parameter int PHW         = 3,
   parameter int FILL_DEPTH  = 8,
   parameter int DRAIN_DEPTH = 8
`ifdef INTERP_UNDERRUN_CNT_EN
   ,
   parameter int CNT_W       = 16
`endif
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           in_valid,
   output logic           in_ready,
   output logic           slow_ce,
   output logic           zero_in,
   output logic [PHW-1:0] phase,
   output logic           acc_clr,
   output logic           out_valid,
   output logic           busy,
   output logic           underrun
`ifdef INTERP_UNDERRUN_CNT_EN
   ,
   output logic [CNT_W-1:0] underrun_cnt
`endif
);

   localparam int MAXD = (FILL_DEPTH > DRAIN_DEPTH) ? FILL_DEPTH : DRAIN_DEPTH;
   localparam int DW   = $clog2(MAXD + 1);

   localparam logic [PHW-1:0] PH_LAST    = PHW'(RATE - 1);
   localparam logic [DW-1:0]  FILL_LAST  = DW'(FILL_DEPTH - 1);
   localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      FILL,
      RUN,
      DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic [PHW-1:0]   phase_d;
   logic [DW-1:0]    cnt_q, cnt_d;
   logic             underrun_d;
   logic             clr_entry;
   logic             ur_event;
   logic             drain_q;

   // Next-state logic. Outputs are registered from the next state so that
   // they line up exactly with the state they describe.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase;
      cnt_d      = cnt_q;
      clr_entry  = 1'b0;
      ur_event   = 1'b0;
      underrun_d = underrun;

      case (state_q)
         IDLE: begin
            phase_d = '0;
            cnt_d   = '0;
            if (en) begin
               state_d   = CLR;
               clr_entry = 1'b1;
            end
         end
         CLR: begin
            state_d = FILL;
            phase_d = '0;
            cnt_d   = '0;
         end
         FILL: begin
            phase_d = (phase == PH_LAST) ? '0 : phase + PHW'(1);
            // Stop at a frame boundary takes priority over FILL completion.
            if (!en && phase == PH_LAST) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else if (cnt_q == FILL_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         RUN: begin
            phase_d  = (phase == PH_LAST) ? '0 : phase + PHW'(1);
            ur_event = (phase == '0) && !in_valid;
            if (!en && phase == PH_LAST) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end
         end
         DRAIN: begin
            phase_d = (phase == PH_LAST) ? '0 : phase + PHW'(1);
            if (cnt_q == DRAIN_LAST) begin
               cnt_d   = '0;
               phase_d = '0;
               if (en) begin
                  state_d   = CLR;
                  clr_entry = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
            cnt_d   = '0;
         end
      endcase

      if (clr_entry)
         underrun_d = 1'b0;
      else if (ur_event)
         underrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         phase     <= '0;
         cnt_q     <= '0;
         underrun  <= 1'b0;
         slow_ce   <= 1'b0;
         in_ready  <= 1'b0;
         acc_clr   <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         drain_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase     <= phase_d;
         cnt_q     <= cnt_d;
         underrun  <= underrun_d;
         slow_ce   <= (state_d == FILL || state_d == RUN || state_d == DRAIN) && (phase_d == '0);
         in_ready  <= (state_d == FILL || state_d == RUN) && (phase_d == '0);
         acc_clr   <= (state_d == CLR);
         out_valid <= (state_d == RUN || state_d == DRAIN);
         busy      <= (state_d != IDLE);
         drain_q   <= (state_d == DRAIN);
      end
   end

`ifdef INTERP_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         underrun_cnt <= '0;
      else if (clr_entry)
         underrun_cnt <= '0;
      else if (ur_event && underrun_cnt != '1)
         underrun_cnt <= underrun_cnt + CNT_W'(1);
   end
`endif

   // Only output with a combinational path from an input.
   assign zero_in = slow_ce & (~in_valid | drain_q);

endmodule

// File: tb/tb_interp_phase_scheduler.sv
module tb_interp_phase_scheduler;

   localparam int RATE        = 8;
   localparam int PHW         = 3;
   localparam int FILL_DEPTH  = 8;
   localparam int DRAIN_DEPTH = 8;
`ifdef INTERP_UNDERRUN_CNT_EN
   localparam int CNT_W       = 16;
   localparam int UMAX        = (1 << CNT_W) - 1;
`endif

   logic           clk;
   logic           rst_n;
   logic           en;
   logic           in_valid;
   logic           in_ready;
   logic           slow_ce;
   logic           zero_in;
   logic [PHW-1:0] phase;
   logic           acc_clr;
   logic           out_valid;
   logic           busy;
   logic           underrun;
`ifdef INTERP_UNDERRUN_CNT_EN
   logic [CNT_W-1:0] underrun_cnt;
`endif

   int checks = 0;
   int errors = 0;

   interp_phase_scheduler #(
      .RATE        (RATE),
      .PHW         (PHW),
      .FILL_DEPTH  (FILL_DEPTH),
      .DRAIN_DEPTH (DRAIN_DEPTH)
`ifdef INTERP_UNDERRUN_CNT_EN
      ,
      .CNT_W       (CNT_W)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .slow_ce   (slow_ce),
      .zero_in   (zero_in),
      .phase     (phase),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .busy      (busy),
      .underrun  (underrun)
`ifdef INTERP_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: the run is described by the mode and by k, the number
   // of fast cycles since FILL was entered; the phase is simply k mod RATE.
   localparam int M_IDLE  = 0;
   localparam int M_CLR   = 1;
   localparam int M_FILL  = 2;
   localparam int M_RUN   = 3;
   localparam int M_DRAIN = 4;

   int m_mode;
   int m_k;
   int m_dstart;
   bit m_und;
`ifdef INTERP_UNDERRUN_CNT_EN
   int m_ucnt;
`endif

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_k      = 0;
      m_dstart = 0;
      m_und    = 1'b0;
`ifdef INTERP_UNDERRUN_CNT_EN
      m_ucnt   = 0;
`endif
   endtask

   task automatic model_clear_stats();
      m_und = 1'b0;
`ifdef INTERP_UNDERRUN_CNT_EN
      m_ucnt = 0;
`endif
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      int ph;
      if (rst_n) begin
         ph = m_k % RATE;
         case (m_mode)
            M_IDLE: begin
               if (en) begin
                  m_mode = M_CLR;
                  model_clear_stats();
               end
            end
            M_CLR: begin
               m_mode = M_FILL;
               m_k    = 0;
            end
            M_FILL, M_RUN: begin
               if (m_mode == M_RUN && ph == 0 && !in_valid) begin
                  m_und = 1'b1;
`ifdef INTERP_UNDERRUN_CNT_EN
                  if (m_ucnt < UMAX) m_ucnt++;
`endif
               end
               if (!en && ph == RATE - 1) begin
                  m_mode   = M_DRAIN;
                  m_dstart = m_k + 1;
               end else if (m_mode == M_FILL && m_k + 1 == FILL_DEPTH) begin
                  m_mode = M_RUN;
               end
               m_k++;
            end
            M_DRAIN: begin
               if (m_k + 1 - m_dstart == DRAIN_DEPTH) begin
                  if (en) begin
                     m_mode = M_CLR;
                     model_clear_stats();
                  end else begin
                     m_mode = M_IDLE;
                  end
               end
               m_k++;
            end
            default: m_mode = M_IDLE;
         endcase
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin : cmp
      bit active;
      bit feed;
      int ph;
      active = (m_mode == M_FILL) || (m_mode == M_RUN) || (m_mode == M_DRAIN);
      feed   = (m_mode == M_FILL) || (m_mode == M_RUN);
      ph     = active ? (m_k % RATE) : 0;
      chk("phase",     32'(phase),     32'(ph));
      chk("slow_ce",   32'(slow_ce),   32'(active && ph == 0));
      chk("in_ready",  32'(in_ready),  32'(feed && ph == 0));
      chk("zero_in",   32'(zero_in),   32'(active && ph == 0 && (!in_valid || m_mode == M_DRAIN)));
      chk("acc_clr",   32'(acc_clr),   32'(m_mode == M_CLR));
      chk("out_valid", 32'(out_valid), 32'(m_mode == M_RUN || m_mode == M_DRAIN));
      chk("busy",      32'(busy),      32'(m_mode != M_IDLE));
      chk("underrun",  32'(underrun),  32'(m_und));
`ifdef INTERP_UNDERRUN_CNT_EN
      chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
   end

   task automatic finish_cycle();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      finish_cycle();
      rst_n = 1'b1;
   endtask

   logic en_r;

   initial begin
      rst_n    = 1'b0;
      en       = 1'b1;
      in_valid = 1'b1;
      model_reset();

      // Held in reset with en and in_valid high: everything quiet.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_busy",    32'(busy),      32'd0);
         chk("rst_slow_ce", 32'(slow_ce),   32'd0);
         chk("rst_zero_in", 32'(zero_in),   32'd0);
         chk("rst_phase",   32'(phase),     32'd0);
         chk("rst_ready",   32'(in_ready),  32'd0);
         finish_cycle();
      end
      rst_n = 1'b1;

      // Run A: underrun at cycle 18, stop at 20, en re-raised at 28 in DRAIN.
      for (int c = 0; c < 40; c++) begin
         en       = !(c >= 20 && c < 28);
         in_valid = (c != 18);
         @(negedge clk);
         case (c)
            1:  chk("A_acc_clr_c1", 32'(acc_clr), 32'd1);
            2:  begin
                   chk("A_slow_ce_c2",  32'(slow_ce),  32'd1);
                   chk("A_in_ready_c2", 32'(in_ready), 32'd1);
                   chk("A_phase_c2",    32'(phase),    32'd0);
                end
            9:  chk("A_out_valid_c9",  32'(out_valid), 32'd0);
            10: begin
                   chk("A_out_valid_c10", 32'(out_valid), 32'd1);
                   chk("A_slow_ce_c10",   32'(slow_ce),   32'd1);
                end
            18: begin
                   chk("A_zero_in_c18",  32'(zero_in),  32'd1);
                   chk("A_in_ready_c18", 32'(in_ready), 32'd1);
                   chk("A_underrun_c18", 32'(underrun), 32'd0);
                end
            19: begin
                   chk("A_underrun_c19", 32'(underrun), 32'd1);
`ifdef INTERP_UNDERRUN_CNT_EN
                   chk("A_ucnt_c19", 32'(underrun_cnt), 32'd1);
`endif
                end
            25: chk("A_phase_c25", 32'(phase), 32'd7);
            26: begin
                   chk("A_in_ready_c26", 32'(in_ready), 32'd0);
                   chk("A_zero_in_c26",  32'(zero_in),  32'd1);
                   chk("A_ov_c26",       32'(out_valid), 32'd1);
                end
            33: chk("A_ov_c33", 32'(out_valid), 32'd1);
            34: begin
                   chk("A_acc_clr_c34",  32'(acc_clr),  32'd1);
                   chk("A_underrun_c34", 32'(underrun), 32'd0);
                end
            35: begin
                   chk("A_in_ready_c35", 32'(in_ready), 32'd1);
                   chk("A_phase_c35",    32'(phase),    32'd0);
                end
            default: ;
         endcase
         finish_cycle();
      end

      // Run B: clean stop at cycle 20, back to IDLE at 34.
      pulse_reset();
      for (int c = 0; c < 38; c++) begin
         en       = (c < 20);
         in_valid = 1'b1;
         @(negedge clk);
         case (c)
            26: begin
                   chk("B_zero_in_c26",  32'(zero_in),  32'd1);
                   chk("B_in_ready_c26", 32'(in_ready), 32'd0);
                end
            33: chk("B_ov_c33", 32'(out_valid), 32'd1);
            34: begin
                   chk("B_busy_c34",  32'(busy),      32'd0);
                   chk("B_ov_c34",    32'(out_valid), 32'd0);
                   chk("B_phase_c34", 32'(phase),     32'd0);
                end
            default: ;
         endcase
         finish_cycle();
      end

      // Run C: reset pulse mid-RUN, then restart through CLR.
      for (int c = 0; c < 22; c++) begin
         en       = 1'b1;
         in_valid = 1'b1;
         rst_n    = (c != 13);
         if (!rst_n) model_reset();
         @(negedge clk);
         case (c)
            12: chk("C_ov_c12", 32'(out_valid), 32'd1);
            13: begin
                   chk("C_busy_c13",  32'(busy),      32'd0);
                   chk("C_ov_c13",    32'(out_valid), 32'd0);
                   chk("C_phase_c13", 32'(phase),     32'd0);
                end
            15: chk("C_acc_clr_c15", 32'(acc_clr), 32'd1);
            16: begin
                   chk("C_in_ready_c16", 32'(in_ready), 32'd1);
                   chk("C_phase_c16",    32'(phase),    32'd0);
                end
            default: ;
         endcase
         finish_cycle();
      end
      rst_n = 1'b1;

      // Random traffic: slow en toggling, sparse underruns, rare resets.
      en_r = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 29) == 0) en_r = ~en_r;
         en       = en_r;
         in_valid = ($urandom_range(0, 99) < 85);
         rst_n    = ($urandom_range(0, 599) != 0);
         if (!rst_n) model_reset();
         @(negedge clk);
         finish_cycle();
      end
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
